// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle between result sources, the N-to-1 selector and its consumer.
interface mux_arb_nto1_if #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_IN     = 3
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_ready;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]             out_src;
  logic                         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 selector, explicit or round-robin, with a one-entry registered output.
// Optional transfer counter enabled by defining MUX_ARB_PERF_EN.
module mux_arb_nto1 #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_IN     = 3,
  localparam int SEL_W     = $clog2(NUM_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_mode,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_err,
`ifdef MUX_ARB_PERF_EN
  output logic [31:0]      xfer_count,
  input  logic             count_clr,
`endif
  mux_arb_nto1_if.slave    bus
);

  logic [SEL_W-1:0]      last_q, last_d;
  logic [SEL_W-1:0]      grant;
  logic                  grant_valid;
  logic                  sel_ok;
  logic                  load;
  logic                  drain;
  logic [DATA_WIDTH-1:0] sel_data;
  int                    idx;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_src_q, out_src_d;
  logic                  sel_err_q, sel_err_d;

  assign sel_ok = int'(sel) < NUM_IN;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (!rr_mode) begin
      grant       = sel;
      grant_valid = sel_ok && bus.in_valid[sel];
    end else begin
      // first valid channel after the last winner
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = (int'(last_q) + k) % NUM_IN;
        if (!grant_valid && bus.in_valid[idx]) begin
          grant       = SEL_W'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign sel_data = bus.in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign drain    = out_valid_q && bus.out_ready;
  assign load     = rst_n && grant_valid
                 && (!out_valid_q || bus.out_ready);

  always_comb begin
    bus.in_ready = '0;
    if (load) bus.in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    sel_err_d   = !rr_mode && !sel_ok;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = grant;
      if (rr_mode) last_d = grant;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      sel_err_q   <= 1'b0;
      last_q      <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      sel_err_q   <= sel_err_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign sel_err       = sel_err_q;

`ifdef MUX_ARB_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr)  cnt_d = '0;
    else if (drain) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Vector table plus scoreboard bench for mux_arb_nto1 (NUM_IN=3, 128-bit).
module tb_mux_arb_nto1;
  localparam int DW = 128;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rr_mode;
  logic [1:0] sel;
  logic       sel_err;
`ifdef MUX_ARB_PERF_EN
  logic [31:0] xfer_count;
  logic        count_clr = 1'b0;
  int          m_cnt = 0;
`endif

  mux_arb_nto1_if #(.DATA_WIDTH(DW), .NUM_IN(NI)) bus ();

  mux_arb_nto1 #(.DATA_WIDTH(DW), .NUM_IN(NI)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rr_mode(rr_mode),
    .sel(sel),
    .sel_err(sel_err),
`ifdef MUX_ARB_PERF_EN
    .xfer_count(xfer_count),
    .count_clr(count_clr),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rr;
    logic [1:0] sel;
    logic [2:0] valid;
    logic       ordy;
    logic [2:0] exp_rdy;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    s;
  } sb_t;

  sb_t         sbq[$];
  vec_t        vt[20];
  int          checks = 0;
  int          errors = 0;
  logic        m_ovalid;
  int          m_last;
  logic [DW-1:0] ch[NI];

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NI; i++)
      bus.in_data[i*DW +: DW] = ch[i];
  endtask

  task automatic model_reset();
    m_ovalid = 1'b0;
    m_last   = NI - 1;
    sbq.delete();
  endtask

  task automatic step(input logic use_tbl, input logic [2:0] tbl_rdy);
    int   g;
    logic ld, hs, exp_err;
    sb_t  e;
    #3;
    g = -1;
    if (rst_n) begin
      if (!rr_mode) begin
        if (sel < 2'd3 && bus.in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 1; k <= NI; k++)
          if (g < 0 && bus.in_valid[(m_last + k) % NI])
            g = (m_last + k) % NI;
      end
    end
    ld = (g >= 0) && (!m_ovalid || bus.out_ready);
    hs = rst_n && m_ovalid && bus.out_ready;
    chk("in_ready", DW'(bus.in_ready), ld ? DW'(3'b1 << g) : '0);
    if (use_tbl) chk("in_ready_tbl", DW'(bus.in_ready), DW'(tbl_rdy));
    chk("out_valid", DW'(bus.out_valid), DW'(m_ovalid));
    if (hs) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", DW'(1), DW'(0));
      end else begin
        e = sbq.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_src", DW'(bus.out_src), DW'(e.s));
      end
    end
    if (ld) begin
      e.d = ch[g];
      e.s = 2'(g);
      sbq.push_back(e);
    end
    exp_err = rst_n && !rr_mode && sel >= 2'd3;
`ifdef MUX_ARB_PERF_EN
    if (!rst_n || count_clr) m_cnt = 0;
    else if (hs) m_cnt++;
`endif
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ld) m_ovalid = 1'b1;
      else if (hs) m_ovalid = 1'b0;
      if (ld && rr_mode) m_last = g;
      if (ld) begin
        ch[g] = ch[g] + 1;
        drive_data();
      end
    end
    chk("sel_err", DW'(sel_err), DW'(exp_err));
`ifdef MUX_ARB_PERF_EN
    chk("xfer_count", DW'(xfer_count), DW'(m_cnt));
`endif
  endtask

  task automatic apply(input vec_t v);
    rr_mode       = v.rr;
    sel           = v.sel;
    bus.in_valid  = v.valid;
    bus.out_ready = v.ordy;
  endtask

  initial begin
    vt[0]  = '{1'b0, 2'd1, 3'b111, 1'b1, 3'b010};
    vt[1]  = '{1'b0, 2'd3, 3'b111, 1'b1, 3'b000};
    vt[2]  = '{1'b0, 2'd3, 3'b111, 1'b1, 3'b000};
    vt[3]  = '{1'b0, 2'd0, 3'b111, 1'b1, 3'b001};
    vt[4]  = '{1'b0, 2'd2, 3'b011, 1'b1, 3'b000};
    vt[5]  = '{1'b1, 2'd0, 3'b111, 1'b1, 3'b001};
    vt[6]  = '{1'b1, 2'd0, 3'b111, 1'b1, 3'b010};
    vt[7]  = '{1'b1, 2'd0, 3'b111, 1'b1, 3'b100};
    vt[8]  = '{1'b1, 2'd0, 3'b111, 1'b1, 3'b001};
    vt[9]  = '{1'b1, 2'd0, 3'b111, 1'b1, 3'b010};
    vt[10] = '{1'b1, 2'd0, 3'b111, 1'b1, 3'b100};
    vt[11] = '{1'b1, 2'd1, 3'b100, 1'b1, 3'b100};
    vt[12] = '{1'b1, 2'd1, 3'b100, 1'b1, 3'b100};
    vt[13] = '{1'b1, 2'd0, 3'b010, 1'b0, 3'b000};
    vt[14] = '{1'b1, 2'd0, 3'b010, 1'b0, 3'b000};
    vt[15] = '{1'b1, 2'd0, 3'b010, 1'b0, 3'b000};
    vt[16] = '{1'b1, 2'd0, 3'b010, 1'b0, 3'b000};
    vt[17] = '{1'b1, 2'd0, 3'b010, 1'b1, 3'b010};
    vt[18] = '{1'b1, 2'd0, 3'b000, 1'b1, 3'b000};
    vt[19] = '{1'b1, 2'd0, 3'b000, 1'b1, 3'b000};

    ch[0] = {16{8'h11}};
    ch[1] = {16{8'hA5}};
    ch[2] = {16{8'h22}};
    drive_data();
    model_reset();

    // reset with all channels requesting
    rst_n         = 1'b0;
    rr_mode       = 1'b0;
    sel           = 2'd1;
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 3'b000);
    rst_n = 1'b1;
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_src", DW'(bus.out_src), '0);

    for (int i = 0; i < 20; i++) begin
      apply(vt[i]);
      step(1'b1, vt[i].exp_rdy);
    end

    // held word during backpressure, then drain+reload
    apply('{1'b1, 2'd0, 3'b001, 1'b1, 3'b000});
    step(1'b1, 3'b001);
    bus.out_ready = 1'b0;
    bus.in_valid  = 3'b110;
    for (int i = 0; i < 4; i++) begin
      chk("held_src", DW'(bus.out_src), DW'(0));
      step(1'b1, 3'b000);
    end
    bus.out_ready = 1'b1;
    step(1'b1, 3'b010);
    chk("reload_valid", DW'(bus.out_valid), DW'(1));
    chk("reload_src", DW'(bus.out_src), DW'(1));

    // reset while a word is held
    bus.in_valid = 3'b111;
    bus.out_ready = 1'b0;
    step(1'b0, 3'b000);
    rr_mode = 1'b0;
    sel     = 2'd3;
    step(1'b0, 3'b000);
    rr_mode = 1'b1;
    rst_n   = 1'b0;
    step(1'b1, 3'b000);
    rst_n = 1'b1;
    chk("mid_rst_data", bus.out_data, '0);
    bus.out_ready = 1'b1;
    step(1'b1, 3'b001);
    step(1'b1, 3'b010);
    step(1'b1, 3'b100);

`ifdef MUX_ARB_PERF_EN
    count_clr = 1'b1;
    step(1'b0, 3'b000);
    count_clr = 1'b0;
    chk("clr_prio", DW'(xfer_count), DW'(0));
    for (int i = 0; i < 10; i++) step(1'b0, 3'b000);
    chk("cnt_10", DW'(xfer_count), DW'(32'd10));
`endif

    bus.in_valid = 3'b000;
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    chk("sb_drained", DW'(sbq.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N-to-1 datapath selector for the SPU operand/result network with a registered, handshaked output. It has two runtime modes: explicit select (a steering field chooses the source) and fair round-robin arbitration among valid sources. An invalid select is reported as an error; it never produces a floating bus. The block sits between forwarding/result sources and a consuming pipeline stage, and decouples them through a one-entry output register.

## Interface
Parameters:
- DATA_WIDTH, 128, width of each data channel.
- NUM_IN, 3, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN), width of sel and out_src (derived; not overridden).

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rr_mode  input  1  0 = explicit select, 1 = round-robin arbitration.
- sel  input  SEL_W  source index in explicit mode; ignored when rr_mode=1.
- in_valid  input  NUM_IN  per-channel valid.
- in_data  input  NUM_IN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_IN  per-channel accept (combinational).
- out_valid  output  1  output register holds data.
- out_data  output  DATA_WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.
- sel_err  output  1  registered error flag for an out-of-range select.
- xfer_count  output  32  output transfer count (present only with MUX_ARB_PERF_EN).
- count_clr  input  1  synchronous clear of xfer_count (present only with MUX_ARB_PERF_EN).

## Operation
- Grant logic is combinational from the current inputs:
  - Explicit mode: grant_valid = (sel < NUM_IN) && in_valid[sel]; grant = sel.
  - Round-robin mode: search starts at (last_grant+1) mod NUM_IN and takes the first channel with in_valid set. grant_valid = |in_valid.
- load = grant_valid && (!out_valid || out_ready).
- in_ready[i] = load && (grant == i). At most one bit of in_ready is set in any cycle.
- On load: out_data ← selected in_data; out_src ← grant; out_valid ← 1.
- If out_valid && out_ready && !load: out_valid ← 0.
- If out_valid && !out_ready: the output register holds; out_data and out_src are stable.
- last_grant updates to grant only on a load in round-robin mode. It is unchanged in explicit mode, so switching modes keeps the fairness pointer.
- sel_err ← (rr_mode==0 && sel >= NUM_IN), registered every cycle. No load occurs while the select is out of range.
- When NUM_IN is a power of two, sel cannot be out of range, and sel_err stays 0.
- Source ordering: data from one channel leaves in acceptance order. There is no reordering and no duplication.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, sel_err=0, last_grant=NUM_IN-1 (first RR priority is channel 0), xfer_count=0.
- Reset taken mid-operation discards the held output word. in_ready is 0 during reset.
- Latency: an input accepted in cycle t is presented at out_valid/out_data in cycle t+1.
- Throughput: one transfer per cycle when out_ready is held high.
- Simultaneous output drain and new load in the same cycle: the register is replaced and out_valid stays 1.
- sel_err asserts the cycle after the bad sel is sampled and deasserts the cycle after sel becomes legal.
- Handshake rules: a source must hold in_data stable while in_valid=1 && in_ready=0. in_valid does not depend on in_ready.

## Configuration
- MUX_ARB_PERF_EN defined:
  - xfer_count increments on every cycle with out_valid && out_ready, and wraps from 0xFFFFFFFF to 0.
  - count_clr=1 forces the count to 0 next cycle; clear takes priority over increment.
- MUX_ARB_PERF_EN undefined: the xfer_count and count_clr ports and the counter logic are absent. All other behaviour is identical.

## Test plan
- Explicit mode, NUM_IN=3, sel=1, in_valid=3'b111, in_data ch1=0xA5…, out_ready=1 → in_ready=3'b010; next cycle out_valid=1, out_data=0xA5…, out_src=1.
- Explicit mode, sel=3 (out of range) with all inputs valid → in_ready=0, no load, sel_err=1 from the next cycle; sel returns to 0 → sel_err=0 one cycle later.
- Round-robin, all three inputs valid continuously, out_ready=1 → out_src sequence 0,1,2,0,1,2 after reset; with only ch2 valid, every grant goes to ch2.
- Backpressure: out_ready=0 for 4 cycles after a load → out_data/out_src held, in_ready=0; out_ready=1 plus a valid input → drain and reload in the same cycle, out_valid stays 1.
- Reset mid-stream: rst_n=0 for one cycle while out_valid=1 → next cycle out_valid=0, out_data=0, sel_err=0, and RR restarts at channel 0.
- With MUX_ARB_PERF_EN: 10 output transfers → xfer_count=10; count_clr pulse coinciding with a transfer → count=0. Preload near 0xFFFFFFFF to check wrap to 0.
